// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, ALUOp classes,
// FSM state type and the packed control word. MULTICYCLE_BNE_EN adds the BNEEX state.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
`ifdef MULTICYCLE_BNE_EN
        , S_BNEEX = 4'd12
`endif
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
    } ctrl_word_t;

endpackage

// File: rtl/multicycle_ctrl_rom.sv
// Pure state -> control-word lookup. FETCH asserts ir_write/pc_write unconditionally;
// the FSM qualifies them with memory readiness. MULTICYCLE_BNE_EN adds the BNEEX row.
module multicycle_ctrl_rom
    import mips_ctrl_pkg::*;
(
    input  state_t     i_state,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.pc_write  = 1'b1;
            end
            S_DECODE:  o_ctrl.alu_src_b = SRCB_IMMSH;
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD:   o_ctrl.iord = 1'b1;
            S_MEMWB: begin
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            S_BEQEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_SUB;
                o_ctrl.pc_src    = PCSRC_ALUOUT;
                o_ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB:  o_ctrl.reg_write = 1'b1;
            S_JEX: begin
                o_ctrl.pc_src   = PCSRC_JUMP;
                o_ctrl.pc_write = 1'b1;
            end
`ifdef MULTICYCLE_BNE_EN
            S_BNEEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_SUB;
                o_ctrl.pc_src    = PCSRC_ALUOUT;
                o_ctrl.branch_ne = 1'b1;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control FSM: state register, next-state decode and gated control outputs.
// MULTICYCLE_BNE_EN enables the bne instruction (BNEEX state); otherwise opcode 000101 is illegal.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter int MEM_WAIT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                iord,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_src,
    output logic                pc_write,
    output logic                branch,
    output logic                branch_ne,
    output logic                illegal_op
);

    state_t     r_state, w_next;
    logic       r_is_sw;
    logic       w_rdy, w_dec_illegal;
    ctrl_word_t w_rom, w_out;

    assign w_rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    // opcode is only valid in DECODE, so remember lw vs sw for the MEMADR fork
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                r_is_sw <= 1'b0;
        else if (r_state == S_DECODE) r_is_sw <= (opcode == OPCODE_W'(OP_SW));
    end

    always_comb begin
        w_next        = r_state;
        w_dec_illegal = 1'b0;
        case (r_state)
            S_FETCH:   if (w_rdy) w_next = S_DECODE;
            S_DECODE: begin
                if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) w_next = S_MEMADR;
                else if (opcode == OPCODE_W'(OP_RTYPE)) w_next = S_RTYPEEX;
                else if (opcode == OPCODE_W'(OP_BEQ))   w_next = S_BEQEX;
                else if (opcode == OPCODE_W'(OP_ADDI))  w_next = S_ADDIEX;
                else if (opcode == OPCODE_W'(OP_J))     w_next = S_JEX;
`ifdef MULTICYCLE_BNE_EN
                else if (opcode == OPCODE_W'(OP_BNE))   w_next = S_BNEEX;
`endif
                else begin
                    w_next        = S_FETCH;
                    w_dec_illegal = 1'b1;
                end
            end
            S_MEMADR:  w_next = r_is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (w_rdy) w_next = S_MEMWB;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   if (w_rdy) w_next = S_FETCH;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_RTYPEWB: w_next = S_FETCH;
            S_BEQEX:   w_next = S_FETCH;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ADDIWB:  w_next = S_FETCH;
            S_JEX:     w_next = S_FETCH;
`ifdef MULTICYCLE_BNE_EN
            S_BNEEX:   w_next = S_FETCH;
`endif
            default:   w_next = S_FETCH;
        endcase
    end

    multicycle_ctrl_rom u_rom (
        .i_state (r_state),
        .o_ctrl  (w_rom)
    );

    // Fetch strobes are the only Mealy terms; reset kills every output immediately
    always_comb begin
        w_out = w_rom;
        if (r_state == S_FETCH) begin
            w_out.ir_write = w_rom.ir_write & w_rdy;
            w_out.pc_write = w_rom.pc_write & w_rdy;
        end
`ifndef MULTICYCLE_BNE_EN
        w_out.branch_ne = 1'b0;
`endif
        if (!reset_n) w_out = '0;
    end

    assign iord       = w_out.iord;
    assign mem_write  = w_out.mem_write;
    assign ir_write   = w_out.ir_write;
    assign reg_dst    = w_out.reg_dst;
    assign mem_to_reg = w_out.mem_to_reg;
    assign reg_write  = w_out.reg_write;
    assign alu_src_a  = w_out.alu_src_a;
    assign alu_src_b  = w_out.alu_src_b;
    assign alu_op     = ALUOP_W'(w_out.alu_op);
    assign pc_src     = w_out.pc_src;
    assign pc_write   = w_out.pc_write;
    assign branch     = w_out.branch;
    assign branch_ne  = w_out.branch_ne;
    assign illegal_op = reset_n & (r_state == S_DECODE) & w_dec_illegal;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction expected control sequences built from the
// instruction semantics, directed corner cases, then randomized instructions and memory stalls.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       pc_write, branch, branch_ne, illegal_op;
    logic [16:0] obs;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        bit          wt;     // step lasts until mem_ready
        bit          fetch;  // ir_write/pc_write follow mem_ready
        logic [16:0] w;
    } step_t;

    step_t plan[$];

    always #5 clk = ~clk;

    multicycle_control_fsm #(.OPCODE_W(6), .ALUOP_W(2), .MEM_WAIT(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .pc_write   (pc_write),
        .branch     (branch),
        .branch_ne  (branch_ne),
        .illegal_op (illegal_op)
    );

    assign obs = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_src, pc_write, branch, branch_ne, illegal_op};

    function automatic logic [16:0] mk(input bit io, input bit mw, input bit irw, input bit rd,
                                       input bit m2r, input bit rw, input bit sa,
                                       input logic [1:0] sb, input logic [1:0] ao,
                                       input logic [1:0] ps, input bit pw, input bit br,
                                       input bit bn, input bit il);
        return {io, mw, irw, rd, m2r, rw, sa, sb, ao, ps, pw, br, bn, il};
    endfunction

    function automatic bit bne_en();
`ifdef MULTICYCLE_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [16:0] act, input logic [16:0] exp);
        n_assert++;
        assert (act === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // Expected cycle-by-cycle control word for one instruction, fetch included
    task automatic build_plan(input logic [5:0] op);
        bit known;
        known = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
                (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010) ||
                (op == 6'b000101 && bne_en());
        plan.delete();
        plan.push_back('{1'b1, 1'b1, mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0,0)});
        plan.push_back('{1'b0, 1'b0, mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0,!known)});
        case (op)
            6'b100011: begin
                plan.push_back('{1'b0, 1'b0, mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0,0)});
                plan.push_back('{1'b1, 1'b0, mk(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0,0)});
                plan.push_back('{1'b0, 1'b0, mk(0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0,0,0)});
            end
            6'b101011: begin
                plan.push_back('{1'b0, 1'b0, mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0,0)});
                plan.push_back('{1'b1, 1'b0, mk(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0,0)});
            end
            6'b000000: begin
                plan.push_back('{1'b0, 1'b0, mk(0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0,0)});
                plan.push_back('{1'b0, 1'b0, mk(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,0,0)});
            end
            6'b000100:
                plan.push_back('{1'b0, 1'b0, mk(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,1,0,0)});
            6'b001000: begin
                plan.push_back('{1'b0, 1'b0, mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0,0)});
                plan.push_back('{1'b0, 1'b0, mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0,0,0)});
            end
            6'b000010:
                plan.push_back('{1'b0, 1'b0, mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,0,0)});
            6'b000101:
                if (bne_en())
                    plan.push_back('{1'b0, 1'b0, mk(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0,1,0)});
            default: ;
        endcase
    endtask

    // Runs one instruction from FETCH; entered and left at posedge+1.
    // Non-random wait steps stall for fstall (fetch) / mstall (memory) cycles.
    task automatic run_instr(input string tag, input logic [5:0] op, input int fstall,
                             input int mstall, input bit rnd, input int abort_k);
        int    k = 0;
        int    cnt = fstall;
        int    guard = 0;
        bit    mr;
        step_t s;
        logic [16:0] exp;
        build_plan(op);
        while (k < plan.size()) begin
            s = plan[k];
            if (s.wt) mr = rnd ? ($urandom_range(0, 2) != 0) : (cnt == 0);
            else      mr = 1'($urandom_range(0, 1));
            mem_ready = mr;
            opcode    = (k == 1) ? op : 6'($urandom);
            @(negedge clk);
            exp = s.w;
            if (s.fetch) begin
                exp[14] = mr;
                exp[3]  = mr;
            end
            check($sformatf("%s step%0d", tag, k), obs, exp);
            if (k == abort_k) return;
            @(posedge clk);
            #1;
            if (!s.wt || mr) begin
                k++;
                cnt = mstall;
            end else begin
                cnt--;
            end
            guard++;
            if (guard > 200) begin
                n_assert++;
                n_fail++;
                $error("FAIL %s timeout: observed %0d cycles expected at most 200", tag, guard);
                return;
            end
        end
    endtask

    initial begin
        logic [5:0] ops [0:6];
        logic [5:0] op;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b000100;
        ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b000101;

        mem_ready = 1'b1;
        @(negedge clk);
        check("reset_outputs", obs, 17'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        run_instr("lw_nowait", 6'b100011, 0, 0, 1'b0, -1);
        run_instr("sw_stall3", 6'b101011, 0, 3, 1'b0, -1);
        run_instr("j_fetchstall2", 6'b000010, 2, 0, 1'b0, -1);
        run_instr("illegal_3f", 6'b111111, 0, 0, 1'b0, -1);
        run_instr("bne", 6'b000101, 0, 0, 1'b0, -1);
        run_instr("beq", 6'b000100, 1, 0, 1'b0, -1);
        run_instr("rtype", 6'b000000, 0, 0, 1'b0, -1);
        run_instr("addi", 6'b001000, 0, 0, 1'b0, -1);
        run_instr("lw_stall2", 6'b100011, 1, 2, 1'b0, -1);

        // reset asserted in the middle of a stalled store
        run_instr("sw_pre_reset", 6'b101011, 0, 5, 1'b0, 3);
        @(posedge clk);
        #1;
        check("memwr_held", obs, mk(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0,0));
        reset_n = 1'b0;
        #1;
        check("reset_kills_memwr", obs, 17'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        check("reset_gates_fetch", obs, 17'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_instr("after_reset_j", 6'b000010, 0, 0, 1'b0, -1);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else                           op = ops[$urandom_range(0, 6)];
            run_instr($sformatf("rand%0d_op%b", i, op), op, 0, 0, 1'b1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
